regfile_wb: RTL and testbench
=============================

// Module: regfile_wb
// PURPOSE
//  Writeback stage directly upstream of the register file: owns its single write port.
//  Merges single-cycle ALU results with variable-latency load results, which are queued
//  in a small FIFO. Keeps a per-register scoreboard of outstanding loads so decode can
//  stall on RAW/WAW hazards.
// PARAMETERS
//  RADDRWIDTH  3   register address width; NREGS = 2**RADDRWIDTH, r0 reads as zero
//  REGWIDTH    16  register data width
//  LDDEPTH     4   load-result FIFO depth, power of two, >= 2
// PORTS
//  clk        in   1           clock, all state on rising edge
//  rst_n      in   1           asynchronous reset, active-low
//  alu_valid  in   1           ALU result present this cycle; always accepted
//  alu_waddr  in   RADDRWIDTH  ALU destination
//  alu_wdata  in   REGWIDTH    ALU result
//  ld_valid   in   1           load result offered
//  ld_ready   out  1           load FIFO can accept (= !full)
//  ld_waddr   in   RADDRWIDTH  load destination
//  ld_wdata   in   REGWIDTH    load data
//  iss_valid  in   1           decode issued a load this cycle
//  iss_waddr  in   RADDRWIDTH  destination of issued load
//  pending    out  NREGS       scoreboard; bit i = load to ri outstanding
//  we         out  1           regfile write enable (registered)
//  waddr      out  RADDRWIDTH  regfile write address (registered)
//  wdata      out  REGWIDTH    regfile write data (registered)
// BEHAVIOUR
//  Reset (rst_n=0, async): we=0, waddr=0, wdata=0, pending=0, FIFO empty, ld_ready=1.
//  Load accept: ld_valid && ld_ready on an edge pushes {ld_waddr,ld_wdata}. Push with
//   ld_waddr=0 is accepted and discarded (never stored, never written).
//  Write select each cycle, ALU has priority:
//   alu_valid && alu_waddr!=0 -> next {we,waddr,wdata} = {1,alu_waddr,alu_wdata};
//   else FIFO non-empty -> pop head, next = {1,head.waddr,head.wdata};
//   else next we=0; waddr/wdata hold previous values.
//  Latency: ALU 1 cycle to we. Load min 2 cycles (push, then pop into output regs).
//   No bypass of an empty FIFO.
//  Simultaneous push and pop: both occur; count unchanged. Pop when full frees a slot
//   only from next cycle (ld_ready from registered count only).
//  Scoreboard: iss_valid && iss_waddr!=0 sets pending[iss_waddr].
//   A load pop clears pending[head.waddr] in the pop cycle; bit 0 is always 0.
//   Set and clear of the same bit in one cycle: set wins.
//  Decode rules (checked by bench assertions, not by RTL): no issue or ALU write to a
//   register whose pending bit is 1; no load result for a register not pending.
//  Starvation: continuous ALU writes may hold loads in the FIFO indefinitely. This is
//   accepted; decode stalls on pending bits, so the ALU stream drains.
//  Reset mid-operation drops FIFO contents and clears pending; no partial write.
// STRUCTURE
//  regfile_pkg: RADDRWIDTH/REGWIDTH localparams, typedef wb_req_t {waddr,wdata}.
//   Shared with the regfile and decode.
//  Sub-module wb_fifo: LDDEPTH x wb_req_t synchronous FIFO.
//   Ports: push, pop, head, full, empty. Uses a count register.
//  Top: write-select mux, output registers, pending vector register.
// TESTING
//  1 ALU only: alu r3=0x1234 at cycle t -> we=1,waddr=3,wdata=0x1234 at t+1;
//    we=0 at t+2.
//  2 Load path: iss r5, then ld r5=0xBEEF -> pending[5]=1 until pop; write at push+2;
//    pending[5]=0 the cycle after pop.
//  3 Priority: ALU r2 every cycle for 3 cycles while load r6 queued
//    -> r2 writes 3x, then r6 write.
//  4 Backpressure: fill 4 loads with ALU busy -> ld_ready=0 and 5th held;
//    drain gives writes in FIFO order.
//  5 Edge: ld to r0 and alu to r0 -> no we; iss r4 in the same cycle as pop of r4
//    -> pending[4] stays 1.
//  6 Async reset mid-drain with FIFO=3 entries -> we=0, pending=0, ld_ready=1
//    immediately, without a clock edge.

Source files
------------

// File: rtl/regfile_pkg.sv
// Shared register-file types: address/data widths and the
// write request bundle used by writeback, regfile and decode.
package regfile_pkg;

  localparam int RADDRWIDTH = 3;
  localparam int REGWIDTH   = 16;
  localparam int NREGS      = 1 << RADDRWIDTH;

  typedef struct packed {
    logic [RADDRWIDTH-1:0] waddr;
    logic [REGWIDTH-1:0]   wdata;
  } wb_req_t;

endpackage

// File: rtl/regfile_wb_fifo.sv
// Load-result FIFO for the writeback stage.
// Ports: push_i/din_i write, pop_i/head_o read, full_o, empty_o.
module wb_fifo
  import regfile_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic    clk,
  input  logic    rst_n,
  input  logic    push_i,
  input  wb_req_t din_i,
  input  logic    pop_i,
  output wb_req_t head_o,
  output logic    full_o,
  output logic    empty_o
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW-1:0] PINC = AW'(1);
  localparam logic [AW:0]   CINC = (AW+1)'(1);
  localparam logic [AW:0]   CMAX = (AW+1)'(DEPTH);

  wb_req_t       mem_q [DEPTH];
  logic [AW-1:0] wr_q;
  logic [AW-1:0] rd_q;
  logic [AW:0]   cnt_q;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      if (push_i) begin
        mem_q[wr_q] <= din_i;
        wr_q        <= wr_q + PINC;
      end
      if (pop_i) begin
        rd_q <= rd_q + PINC;
      end
      unique case ({push_i, pop_i})
        2'b10:   cnt_q <= cnt_q + CINC;
        2'b01:   cnt_q <= cnt_q - CINC;
        default: ;
      endcase
    end
  end

  assign head_o  = mem_q[rd_q];
  assign full_o  = (cnt_q == CMAX);
  assign empty_o = (cnt_q == '0);

endmodule

// File: rtl/regfile_wb.sv
// Writeback stage owning the regfile write port.
// ALU results win over queued loads; pending tracks loads in flight.
// In: alu_*, ld_valid/ld_waddr/ld_wdata, iss_valid/iss_waddr.
// Out: ld_ready, pending, we/waddr/wdata (registered).
module regfile_wb
  import regfile_pkg::*;
#(
  parameter int LDDEPTH = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  alu_valid,
  input  logic [RADDRWIDTH-1:0] alu_waddr,
  input  logic [REGWIDTH-1:0]   alu_wdata,
  input  logic                  ld_valid,
  output logic                  ld_ready,
  input  logic [RADDRWIDTH-1:0] ld_waddr,
  input  logic [REGWIDTH-1:0]   ld_wdata,
  input  logic                  iss_valid,
  input  logic [RADDRWIDTH-1:0] iss_waddr,
  output logic [NREGS-1:0]      pending,
  output logic                  we,
  output logic [RADDRWIDTH-1:0] waddr,
  output logic [REGWIDTH-1:0]   wdata
);

  logic                  alu_wr;
  logic                  fifo_push;
  logic                  fifo_pop;
  logic                  fifo_full;
  logic                  fifo_empty;
  wb_req_t               ld_req;
  wb_req_t               head;

  logic                  we_q;
  logic                  we_d;
  logic [RADDRWIDTH-1:0] waddr_q;
  logic [RADDRWIDTH-1:0] waddr_d;
  logic [REGWIDTH-1:0]   wdata_q;
  logic [REGWIDTH-1:0]   wdata_d;
  logic [NREGS-1:0]      pend_q;
  logic [NREGS-1:0]      pend_d;

  assign alu_wr    = alu_valid && (alu_waddr != '0);
  assign ld_ready  = !fifo_full;
  // r0 loads complete the handshake but never enter the queue.
  assign fifo_push = ld_valid && ld_ready && (ld_waddr != '0);
  assign fifo_pop  = !alu_wr && !fifo_empty;
  assign ld_req    = '{waddr: ld_waddr, wdata: ld_wdata};

  wb_fifo #(
    .DEPTH(LDDEPTH)
  ) u_fifo (
    .clk    (clk),
    .rst_n  (rst_n),
    .push_i (fifo_push),
    .din_i  (ld_req),
    .pop_i  (fifo_pop),
    .head_o (head),
    .full_o (fifo_full),
    .empty_o(fifo_empty)
  );

  always_comb begin
    we_d    = 1'b0;
    waddr_d = waddr_q;
    wdata_d = wdata_q;
    pend_d  = pend_q;
    unique case (1'b1)
      alu_wr: begin
        we_d    = 1'b1;
        waddr_d = alu_waddr;
        wdata_d = alu_wdata;
      end
      fifo_pop: begin
        we_d               = 1'b1;
        waddr_d            = head.waddr;
        wdata_d            = head.wdata;
        pend_d[head.waddr] = 1'b0;
      end
      default: ;
    endcase
    // Applied after the clear so a same-cycle reissue stays pending.
    if (iss_valid) begin
      pend_d[iss_waddr] = 1'b1;
    end
    pend_d[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      we_q    <= 1'b0;
      waddr_q <= '0;
      wdata_q <= '0;
      pend_q  <= '0;
    end else begin
      we_q    <= we_d;
      waddr_q <= waddr_d;
      wdata_q <= wdata_d;
      pend_q  <= pend_d;
    end
  end

  assign we      = we_q;
  assign waddr   = waddr_q;
  assign wdata   = wdata_q;
  assign pending = pend_q;

endmodule

// File: tb/tb_regfile_wb.sv
// Scoreboard bench for regfile_wb: directed scenarios then
// random traffic against a queue-based reference model.
module tb_regfile_wb;
  import regfile_pkg::*;

  localparam int LDDEPTH = 4;

  logic                  clk = 1'b0;
  logic                  rst_n = 1'b0;
  logic                  alu_valid = 1'b0;
  logic [RADDRWIDTH-1:0] alu_waddr = '0;
  logic [REGWIDTH-1:0]   alu_wdata = '0;
  logic                  ld_valid = 1'b0;
  logic                  ld_ready;
  logic [RADDRWIDTH-1:0] ld_waddr = '0;
  logic [REGWIDTH-1:0]   ld_wdata = '0;
  logic                  iss_valid = 1'b0;
  logic [RADDRWIDTH-1:0] iss_waddr = '0;
  logic [NREGS-1:0]      pending;
  logic                  we;
  logic [RADDRWIDTH-1:0] waddr;
  logic [REGWIDTH-1:0]   wdata;

  always #5 clk = ~clk;

  regfile_wb #(
    .LDDEPTH(LDDEPTH)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .alu_valid(alu_valid),
    .alu_waddr(alu_waddr),
    .alu_wdata(alu_wdata),
    .ld_valid (ld_valid),
    .ld_ready (ld_ready),
    .ld_waddr (ld_waddr),
    .ld_wdata (ld_wdata),
    .iss_valid(iss_valid),
    .iss_waddr(iss_waddr),
    .pending  (pending),
    .we       (we),
    .waddr    (waddr),
    .wdata    (wdata)
  );

  typedef struct {
    logic [RADDRWIDTH-1:0] a;
    logic [REGWIDTH-1:0]   d;
  } ent_t;

  // Reference model: load queue, pending set, expected writes.
  ent_t                  mq[$];
  ent_t                  expq[$];
  logic [NREGS-1:0]      mpend = '0;
  logic [RADDRWIDTH-1:0] mla = '0;
  logic [REGWIDTH-1:0]   mld = '0;
  ent_t                  mh;
  bit                    macc;

  int n_cmp = 0;
  int n_err = 0;
  bit drain_to = 1'b0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mq.delete();
      expq.delete();
      mpend = '0;
      mla   = '0;
      mld   = '0;
    end else begin
      macc = ld_valid && (mq.size() < LDDEPTH);
      if (alu_valid && alu_waddr != 0) begin
        mh.a = alu_waddr;
        mh.d = alu_wdata;
        expq.push_back(mh);
        mla = mh.a;
        mld = mh.d;
      end else if (mq.size() > 0) begin
        mh = mq.pop_front();
        expq.push_back(mh);
        mpend[mh.a] = 1'b0;
        mla = mh.a;
        mld = mh.d;
      end
      if (macc && ld_waddr != 0) begin
        mh.a = ld_waddr;
        mh.d = ld_wdata;
        mq.push_back(mh);
      end
      if (iss_valid && iss_waddr != 0) mpend[iss_waddr] = 1'b1;
    end
  end

  function automatic void chk(string nm, logic [31:0] act,
                              logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp,
               $time);
    end
  endfunction

  ent_t me;
  bit   mexp;

  // Monitor: compares DUT outputs against the model on each negedge.
  always begin
    @(negedge clk or negedge rst_n);
    if (!rst_n) begin
      #1;
      chk("rst_we", 32'(we), 32'd0);
      chk("rst_pending", 32'(pending), 32'd0);
      chk("rst_ld_ready", 32'(ld_ready), 32'd1);
      chk("rst_waddr", 32'(waddr), 32'd0);
      chk("rst_wdata", 32'(wdata), 32'd0);
    end else begin
      if (drain_to) begin
        chk("drain_timeout", 32'd1, 32'(expq.size() == 0 && 1'b0));
        drain_to = 1'b0;
      end
      mexp = (expq.size() > 0);
      chk("we", 32'(we), 32'(mexp));
      if (mexp) begin
        me = expq.pop_front();
        chk("waddr", 32'(waddr), 32'(me.a));
        chk("wdata", 32'(wdata), 32'(me.d));
      end else begin
        chk("hold_waddr", 32'(waddr), 32'(mla));
        chk("hold_wdata", 32'(wdata), 32'(mld));
      end
      chk("pending", 32'(pending), 32'(mpend));
      chk("ld_ready", 32'(ld_ready), 32'(mq.size() < LDDEPTH));
    end
  end

  task automatic put(input bit av, input logic [2:0] aa,
                     input logic [15:0] ad, input bit lv,
                     input logic [2:0] la, input logic [15:0] ldd,
                     input bit iv, input logic [2:0] ia);
    alu_valid = av;
    alu_waddr = aa;
    alu_wdata = ad;
    ld_valid  = lv;
    ld_waddr  = la;
    ld_wdata  = ldd;
    iss_valid = iv;
    iss_waddr = ia;
  endtask

  task automatic drv(input bit av, input logic [2:0] aa,
                     input logic [15:0] ad, input bit lv,
                     input logic [2:0] la, input logic [15:0] ldd,
                     input bit iv, input logic [2:0] ia);
    @(negedge clk);
    #1;
    put(av, aa, ad, lv, la, ldd, iv, ia);
  endtask

  task automatic idle(input int n);
    repeat (n) drv(0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic iss(input logic [2:0] r);
    drv(0, 0, 0, 0, 0, 0, 1, r);
  endtask

  logic [2:0] outst[$];
  bit         av, lv, iv;
  logic [2:0] aa, la, ia;
  int         k;
  int         guard;

  task automatic rnd_cycle(input bit en_alu, input bit en_iss);
    @(negedge clk);
    #1;
    aa = 3'($urandom_range(0, 7));
    av = en_alu && ($urandom_range(0, 1) == 1) && !mpend[aa];
    ia = 3'($urandom_range(1, 7));
    iv = en_iss && ($urandom_range(0, 2) == 0) && !mpend[ia] &&
         !(av && aa == ia);
    lv = 1'b0;
    la = '0;
    k  = 0;
    if (outst.size() > 0 && $urandom_range(0, 1) == 1) begin
      k  = $urandom_range(0, outst.size() - 1);
      la = outst[k];
      lv = 1'b1;
    end
    put(av, aa, 16'($urandom), lv, la, 16'($urandom), iv, ia);
    if (lv && mq.size() < LDDEPTH) outst.delete(k);
    if (iv) outst.push_back(ia);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    #3 rst_n = 1'b1;

    // ALU only
    drv(1, 3, 16'h1234, 0, 0, 0, 0, 0);
    idle(2);

    // Load path
    iss(5);
    idle(1);
    drv(0, 0, 0, 1, 5, 16'hBEEF, 0, 0);
    idle(3);

    // ALU priority over a queued load
    iss(6);
    drv(1, 2, 16'h0A01, 1, 6, 16'h6666, 0, 0);
    drv(1, 2, 16'h0A02, 0, 0, 0, 0, 0);
    drv(1, 2, 16'h0A03, 0, 0, 0, 0, 0);
    idle(3);

    // Backpressure: four loads queued behind ALU, fifth held
    iss(1); iss(3); iss(4); iss(5); iss(7);
    drv(1, 2, 16'hB001, 1, 1, 16'h1111, 0, 0);
    drv(1, 2, 16'hB002, 1, 3, 16'h3333, 0, 0);
    drv(1, 2, 16'hB003, 1, 4, 16'h4444, 0, 0);
    drv(1, 2, 16'hB004, 1, 5, 16'h5555, 0, 0);
    drv(1, 2, 16'hB005, 1, 7, 16'h7777, 0, 0);
    drv(1, 2, 16'hB006, 1, 7, 16'h7777, 0, 0);
    drv(0, 0, 0, 1, 7, 16'h7777, 0, 0);
    drv(0, 0, 0, 1, 7, 16'h7777, 0, 0);
    idle(6);

    // r0 targets never write
    drv(1, 0, 16'hDEAD, 1, 0, 16'hF00D, 0, 0);
    idle(2);

    // Reissue of r4 in its pop cycle keeps it pending
    iss(4);
    drv(0, 0, 0, 1, 4, 16'h4A4A, 0, 0);
    iss(4);
    idle(1);
    drv(0, 0, 0, 1, 4, 16'h4B4B, 0, 0);
    idle(3);

    // Async reset with three loads queued
    iss(1); iss(3); iss(5);
    drv(1, 2, 16'hC001, 1, 1, 16'h0101, 0, 0);
    drv(1, 2, 16'hC002, 1, 3, 16'h0303, 0, 0);
    drv(1, 2, 16'hC003, 1, 5, 16'h0505, 0, 0);
    @(negedge clk);
    #1;
    put(0, 0, 0, 0, 0, 0, 0, 0);
    #1 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    #3 rst_n = 1'b1;
    idle(2);

    // Random traffic
    for (int c = 0; c < 600; c++) begin
      rnd_cycle(1'b1, 1'b1);
    end
    guard = 0;
    while ((outst.size() > 0 || mpend != '0) && guard < 300) begin
      rnd_cycle(1'b0, 1'b0);
      guard++;
    end
    if (guard >= 300) drain_to = 1'b1;
    idle(4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule
